// File: rtl/fir_tdm_multichannel_filter.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks every tap of every channel per frame.
// Optional macro FIR_TDM_SAT_EN saturates the scaled result; otherwise it wraps to DATA_W bits.
//
// state | meaning
// IDLE  | accept a frame, coefficient writes and flush
// MAC   | one tap per cycle; extra drain cycle after the last tap
// OUT   | hold out_data with out_valid until out_ready
module fir_tdm_multichannel_filter #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 12,
    parameter int COEF_FRAC = 11,
    parameter int TAPS      = 31,
    parameter int CHANNELS  = 2,
    parameter int ACC_W     = 41
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic [COEF_W-1:0]            coef_wdata,
    output logic                         coef_wr_ok,
    input  logic                         flush
);
    localparam int AW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(64'(1) << (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'(1) << (DATA_W - 1)) - 64'(1));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  dl [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [AW-1:0]             tap;
    logic [CW-1:0]             ch;
    logic                      drain;

    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  res;

    // The final tap's product is folded in combinationally so the stored result is complete.
    always_comb begin
        prod    = dl[ch][tap] * coef[tap];
        sum     = acc + ACC_W'(prod);
        shifted = (sum + ROUND) >>> COEF_FRAC;
`ifdef FIR_TDM_SAT_EN
        if (shifted > SAT_MAX)
            res = DATA_W'(SAT_MAX);
        else if (shifted < SAT_MIN)
            res = DATA_W'(SAT_MIN);
        else
            res = DATA_W'(shifted);
`else
        res = DATA_W'(shifted);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            coef_wr_ok <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            acc        <= '0;
            tap        <= '0;
            ch         <= '0;
            drain      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                for (int t = 0; t < TAPS; t++)
                    dl[c][t] <= '0;
            for (int t = 0; t < TAPS; t++)
                coef[t] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < TAPS))
                        coef[coef_addr] <= coef_wdata;
                    if (flush) begin
                        for (int c = 0; c < CHANNELS; c++)
                            for (int t = 0; t < TAPS; t++)
                                dl[c][t] <= '0;
                    end else if (in_valid) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int t = TAPS - 1; t > 0; t--)
                                dl[c][t] <= dl[c][t-1];
                            dl[c][0] <= in_data[c*DATA_W +: DATA_W];
                        end
                        acc        <= '0;
                        ch         <= '0;
                        tap        <= '0;
                        drain      <= 1'b0;
                        state      <= MAC;
                        in_ready   <= 1'b0;
                        coef_wr_ok <= 1'b0;
                    end
                end
                MAC: begin
                    if (drain) begin
                        drain     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (tap == AW'(TAPS - 1)) begin
                        out_data[ch*DATA_W +: DATA_W] <= res;
                        if (ch == CW'(CHANNELS - 1)) begin
                            drain <= 1'b1;
                        end else begin
                            ch  <= ch + 1'b1;
                            tap <= '0;
                            acc <= '0;
                        end
                    end else begin
                        acc <= sum;
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        coef_wr_ok <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
